// File: rtl/bus_source_arbiter_pkg.sv
// Shared constants, state encoding and channel helpers for the five-source bus arbiter.
package bus_source_arbiter_pkg;

    localparam int NUM_CH   = 5;
    localparam int SEL_SIZE = 3;
    localparam int HOLD_MAX = 8;
    localparam int CNT_SIZE = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // One-hot owner vector for a channel number in 0..NUM_CH-1.
    function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_SIZE-1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh     = {NUM_CH{1'b0}};
        oh[ch] = 1'b1;
        return oh;
    endfunction

    // Channel reached by stepping ofs places after ch, wrapping NUM_CH-1 -> 0.
    function automatic logic [SEL_SIZE-1:0] wrap_add(input logic [SEL_SIZE-1:0] ch,
                                                     input logic [SEL_SIZE:0]   ofs);
        logic [SEL_SIZE:0] sum;
        sum = {1'b0, ch} + ofs;
        if (sum >= (SEL_SIZE+1)'(NUM_CH)) begin
            sum = sum - (SEL_SIZE+1)'(NUM_CH);
        end else begin
            sum = sum;
        end
        return sum[SEL_SIZE-1:0];
    endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_next_channel.sv
// Round-robin pick: first requesting, unmasked channel after 'last', wrapping.
module rr_next_channel
    import bus_source_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0]   req,
    input  logic [SEL_SIZE-1:0] last,
    input  logic [NUM_CH-1:0]   mask,
    output logic [SEL_SIZE-1:0] pick,
    output logic                found
);

    logic [NUM_CH-1:0]   cand_s;
    logic [SEL_SIZE-1:0] idx_s;

    // Scan farthest-to-nearest so the channel right after 'last' wins.
    always_comb begin
        cand_s = req & ~mask;
        pick   = {SEL_SIZE{1'b0}};
        found  = 1'b0;
        idx_s  = {SEL_SIZE{1'b0}};
        for (int k = NUM_CH; k >= 1; k--) begin
            idx_s = wrap_add(last, (SEL_SIZE+1)'(k));
            pick  = cand_s[idx_s] ? idx_s : pick;
            found = found | cand_s[idx_s];
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner selection for the 5-channel bus mux, with a bounded tenure
// of hold_max accepted beats whenever another source is waiting.
module bus_source_arbiter
    import bus_source_arbiter_pkg::*;
#(
    parameter int hold_max = HOLD_MAX,
    parameter int cnt_size = CNT_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   req,
    input  logic                bus_ready,
    output logic [SEL_SIZE-1:0] sel,
    output logic [NUM_CH-1:0]   grant,
    output logic                bus_valid,
    output logic                beat_done
);

    state_t              state_r, state_n_s;
    logic [SEL_SIZE-1:0] last_r, last_n_s, sel_n_s;
    logic [NUM_CH-1:0]   grant_n_s, mask_s;
    logic [cnt_size-1:0] cnt_r, cnt_n_s;
    logic [SEL_SIZE-1:0] pick_s;
    logic                found_s;
    logic                owner_req_s;

    // The current owner is excluded so a forced rotation always moves on.
    assign mask_s      = (state_r == ST_OWN) ? grant : {NUM_CH{1'b0}};
    assign owner_req_s = req[sel];
    assign bus_valid   = (state_r == ST_OWN) & owner_req_s;
    assign beat_done   = bus_valid & bus_ready;

    rr_next_channel u_next (
        .req   (req),
        .last  (last_r),
        .mask  (mask_s),
        .pick  (pick_s),
        .found (found_s)
    );

    // Next-state and next-owner decision.
    always_comb begin
        state_n_s = state_r;
        sel_n_s   = sel;
        grant_n_s = grant;
        last_n_s  = last_r;
        cnt_n_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_n_s = ST_OWN;
                    sel_n_s   = pick_s;
                    grant_n_s = sel_to_onehot(pick_s);
                    last_n_s  = pick_s;
                    cnt_n_s   = {cnt_size{1'b0}};
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    if (found_s) begin
                        sel_n_s   = pick_s;
                        grant_n_s = sel_to_onehot(pick_s);
                        last_n_s  = pick_s;
                    end else begin
                        state_n_s = ST_IDLE;
                        grant_n_s = {NUM_CH{1'b0}};
                    end
                    cnt_n_s = {cnt_size{1'b0}};
                end else if (beat_done) begin
                    // Count saturates at hold_max; rotation waits for a beat once saturated.
                    if (found_s && (cnt_r >= cnt_size'(hold_max - 1))) begin
                        sel_n_s   = pick_s;
                        grant_n_s = sel_to_onehot(pick_s);
                        last_n_s  = pick_s;
                        cnt_n_s   = {cnt_size{1'b0}};
                    end else if (cnt_r != cnt_size'(hold_max)) begin
                        cnt_n_s = cnt_r + cnt_size'(1);
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end else begin
                    cnt_n_s = cnt_r;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                grant_n_s = {NUM_CH{1'b0}};
                cnt_n_s   = {cnt_size{1'b0}};
            end
        endcase
    end

    // State, owner and tenure registers; last starts at the top channel so ch0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel     <= {SEL_SIZE{1'b0}};
            grant   <= {NUM_CH{1'b0}};
            last_r  <= SEL_SIZE'(NUM_CH - 1);
            cnt_r   <= {cnt_size{1'b0}};
        end else begin
            state_r <= state_n_s;
            sel     <= sel_n_s;
            grant   <= grant_n_s;
            last_r  <= last_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench: stimulus queues the expected owner of every accepted beat,
// a negedge monitor pops and compares on each beat_done.
module tb_bus_source_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       bus_ready;
    logic [2:0] sel;
    logic [4:0] grant;
    logic       bus_valid;
    logic       beat_done;

    int         checks;
    int         errors;
    logic [2:0] exp_q[$];

    bus_source_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bus_ready (bus_ready),
        .sel       (sel),
        .grant     (grant),
        .bus_valid (bus_valid),
        .beat_done (beat_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted beat must match the next queued owner.
    always @(negedge clk) begin
        if (!rst && beat_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got sel %0d expected no beat at %0t", sel, $time);
            end else begin
                logic [2:0] e;
                logic [4:0] eg;
                e  = exp_q.pop_front();
                eg = 5'b00001 << e;
                check("beat_sel", 32'(sel), 32'(e));
                check("beat_grant", 32'(grant), 32'(eg));
            end
        end
    end

    task automatic push_n(input int n, input logic [2:0] ch);
        for (int i = 0; i < n; i++) exp_q.push_back(ch);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    // Asynchronous pulse away from the clock edge; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst       = 1'b1;
        req       = 5'b00000;
        bus_ready = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_beat", 32'(beat_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req       = 5'b00000;
        bus_ready = 1'b0;

        // 1: reset, then idle for ten cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_sel", 32'(sel), 32'd0);
            check("idle_valid", 32'(bus_valid), 32'd0);
        end
        // reset in the middle of a ch1 tenure
        @(posedge clk); #1;
        req = 5'b00010;
        @(posedge clk); #1;
        check("pre_rst_grant", 32'(grant), 32'h02);
        do_reset();

        // 2: single requester, one grant cycle of latency
        req       = 5'b00100;
        bus_ready = 1'b1;
        push_n(3, 3'd2);
        @(negedge clk);
        check("lat_grant", 32'(grant), 32'd0);
        check("lat_valid", 32'(bus_valid), 32'd0);
        wait_drain("t2");
        req       = 5'b00000;
        bus_ready = 1'b0;

        // 3: ch0 and ch4 from reset, 8-beat tenures with wrap back to ch0
        do_reset();
        req       = 5'b10001;
        bus_ready = 1'b1;
        push_n(8, 3'd0);
        push_n(8, 3'd4);
        push_n(8, 3'd0);
        wait_drain("t3");
        req       = 5'b00000;
        bus_ready = 1'b0;

        // 4: stalled owner ch1 must not rotate or count
        do_reset();
        req = 5'b01010;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_sel", 32'(sel), 32'd1);
            check("stall_valid", 32'(bus_valid), 32'd1);
        end
        @(posedge clk); #1;
        bus_ready = 1'b1;
        push_n(8, 3'd1);
        push_n(8, 3'd3);
        wait_drain("t4");
        req       = 5'b00000;
        bus_ready = 1'b0;

        // 5: release with direct handoff, then release to idle
        do_reset();
        req = 5'b01000;
        @(posedge clk); #1;
        check("own3_sel", 32'(sel), 32'd3);
        req = 5'b00001;
        @(negedge clk);
        check("drop_valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        check("handoff_sel", 32'(sel), 32'd0);
        check("handoff_grant", 32'(grant), 32'h01);
        check("handoff_valid", 32'(bus_valid), 32'd1);
        do_reset();
        req = 5'b01000;
        @(posedge clk); #1;
        req = 5'b00000;
        @(posedge clk); #1;
        check("rel_grant", 32'(grant), 32'd0);
        check("rel_sel", 32'(sel), 32'd3);
        check("rel_valid", 32'(bus_valid), 32'd0);

        // 6: lone ch2 saturates, newcomer ch3 takes over after one more beat
        do_reset();
        req       = 5'b00100;
        bus_ready = 1'b1;
        push_n(30, 3'd2);
        wait_drain("t6a");
        req = 5'b01100;
        push_n(1, 3'd2);
        push_n(3, 3'd3);
        wait_drain("t6b");
        req       = 5'b00000;
        bus_ready = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
